// File: rtl/sync_fifo_pkg.sv
// Shared types and constants for the single-clock mode-selectable FIFO.
//   fifo_mode_e  : read mode selector (standard registered read or first-word-fall-through)
//   PARITY_BITS  : extra storage bits per word, 1 when SYNC_FIFO_PARITY_EN is defined, else 0
//   level_width  : bits needed to hold an occupancy count of 0..depth
// Build option: SYNC_FIFO_PARITY_EN adds one even-parity bit per stored word.
package sync_fifo_pkg;

  typedef enum logic [0:0] {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

`ifdef SYNC_FIFO_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Count of 0..depth inclusive needs one more bit than the address for power-of-two depths.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
//   clk_i, rst_ni   : clock and synchronous active-low reset (read register only)
//   clr_i           : synchronous clear of the read register
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i    : read request; rdata_o updates on the following edge and holds otherwise
// The array itself is never reset. A read and write to the same address in one cycle returns
// the old word.
module sync_fifo_ram #(
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (clr_i) begin
      rdata_d = '0;
    end else if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_low(rst_ni)) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  function automatic logic rst_n_low(input logic r);
    return r;
  endfunction

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_mode.sv
// Single-clock FIFO with selectable read mode, occupancy level, watermarks, flush and
// sticky error flags.
//   clk, rst_n (sync, active-low), clr (sync flush, keeps sticky flags)
//   wr_en/wr_data, full (level >= DEPTH-RESERVE), almost_full (level >= AF_LEVEL)
//   rd_en/rd_data, empty, has_data (= !empty), almost_empty (level <= AE_LEVEL)
//   level (0..DEPTH, counts the FWFT output word), overflow/underflow (sticky)
//   parity_err (sticky, only when SYNC_FIFO_PARITY_EN is defined)
// FWFT=1 uses the RAM read register as the output register and prefetches into it whenever
// it is empty or being popped, so back-to-back pops run at one word per cycle.
module sync_fifo_mode
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RESERVE    = 0,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  has_data,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
`ifdef SYNC_FIFO_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned PtrW   = ADDR_WIDTH + 1;
  localparam int unsigned LevelW = level_width(DEPTH);
  localparam int unsigned StoreW = DATA_WIDTH + PARITY_BITS;
  localparam fifo_mode_e  Mode   = (FWFT != 0) ? MODE_FWFT : MODE_STD;

  localparam logic [LevelW-1:0] DepthL = LevelW'(DEPTH);
  localparam logic [LevelW-1:0] FullL  = LevelW'(DEPTH - RESERVE);
  localparam logic [LevelW-1:0] AfL    = LevelW'(AF_LEVEL);
  localparam logic [LevelW-1:0] AeL    = LevelW'(AE_LEVEL);

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mem_count;
  logic [LevelW-1:0] level_q, level_d;
  logic              full_q, full_d, af_q, af_d, empty_q, empty_d, ae_q, ae_d;
  logic              out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              wr_accept, rd_accept, ram_we, ram_re;
  logic [StoreW-1:0] ram_wdata, ram_rdata;

  always_comb begin
    // Words still inside the RAM; in FWFT mode this excludes the word in the output register.
    mem_count = wr_ptr_q - rd_ptr_q;

    if (Mode == MODE_FWFT) begin
      rd_accept = rd_en && out_valid_q;
    end else begin
      rd_accept = rd_en && (level_q != '0);
    end
    wr_accept = wr_en && ((level_q < DepthL) || rd_accept);

    ram_we = wr_accept && !clr;
    if (Mode == MODE_FWFT) begin
      ram_re = !clr && (mem_count != '0) && (!out_valid_q || rd_accept);
    end else begin
      ram_re = rd_accept && !clr;
    end

    wr_ptr_d = clr ? '0 : wr_ptr_q + PtrW'(ram_we);
    rd_ptr_d = clr ? '0 : rd_ptr_q + PtrW'(ram_re);

    level_d = level_q;
    if (clr) begin
      level_d = '0;
    end else if (wr_accept && !rd_accept) begin
      level_d = level_q + LevelW'(1);
    end else if (!wr_accept && rd_accept) begin
      level_d = level_q - LevelW'(1);
    end

    out_valid_d = out_valid_q;
    if (Mode != MODE_FWFT || clr) begin
      out_valid_d = 1'b0;
    end else if (ram_re) begin
      out_valid_d = 1'b1;
    end else if (rd_accept) begin
      out_valid_d = 1'b0;
    end

    empty_d = (Mode == MODE_FWFT) ? !out_valid_d : (level_d == '0);
    full_d  = (level_d >= FullL);
    af_d    = (level_d >= AfL);
    ae_d    = (level_d <= AeL);

    // A flush swallows same-cycle requests, so they cannot raise the sticky flags either.
    overflow_d  = overflow_q  | (wr_en && !wr_accept && !clr);
    underflow_d = underflow_q | (rd_en && !rd_accept && !clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      af_q        <= 1'b0;
      empty_q     <= 1'b1;
      ae_q        <= 1'b1;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      af_q        <= af_d;
      empty_q     <= empty_d;
      ae_q        <= ae_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_ram #(
    .Width(StoreW),
    .AddrW(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr),
    .we_i   (ram_we),
    .waddr_i(wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i(ram_wdata),
    .re_i   (ram_re),
    .raddr_i(rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o(ram_rdata)
  );

`ifdef SYNC_FIFO_PARITY_EN
  logic fresh_q, perr_now, parity_err_q;

  assign ram_wdata = {^wr_data, wr_data};
  // fresh_q marks the cycle a word has just left storage into the read register.
  assign perr_now   = fresh_q && (^ram_rdata);
  assign parity_err = parity_err_q | perr_now;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fresh_q      <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      fresh_q      <= ram_re;
      parity_err_q <= parity_err;
    end
  end
`else
  assign ram_wdata = wr_data;
`endif

  assign rd_data      = ram_rdata[DATA_WIDTH-1:0];
  assign level        = level_q;
  assign full         = full_q;
  assign almost_full  = af_q;
  assign empty        = empty_q;
  assign has_data     = !empty_q;
  assign almost_empty = ae_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_mode.sv
// Directed bench for sync_fifo_mode: three instances (standard, FWFT, standard with RESERVE=2)
// share one clock and reset. Parity checks are compiled in with SYNC_FIFO_PARITY_EN.
module tb_sync_fifo_mode;

  localparam int NumDut = 3;
  localparam int IStd   = 0;
  localparam int IFwft  = 1;
  localparam int IRsv   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr          [NumDut];
  logic       wr_en        [NumDut];
  logic       rd_en        [NumDut];
  logic [7:0] wr_data      [NumDut];
  logic [7:0] rd_data      [NumDut];
  logic       full         [NumDut];
  logic       almost_full  [NumDut];
  logic       empty        [NumDut];
  logic       has_data     [NumDut];
  logic       almost_empty [NumDut];
  logic       overflow     [NumDut];
  logic       underflow    [NumDut];
  logic [4:0] level        [NumDut];
`ifdef SYNC_FIFO_PARITY_EN
  logic       parity_err   [NumDut];
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    sync_fifo_mode #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(4),
      .RESERVE   ((g == 2) ? 2 : 0),
      .FWFT      ((g == 1) ? 1 : 0),
      .AF_LEVEL  (14),
      .AE_LEVEL  (2)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr[g]),
      .wr_en       (wr_en[g]),
      .wr_data     (wr_data[g]),
      .full        (full[g]),
      .almost_full (almost_full[g]),
      .rd_en       (rd_en[g]),
      .rd_data     (rd_data[g]),
      .empty       (empty[g]),
      .has_data    (has_data[g]),
      .almost_empty(almost_empty[g]),
      .level       (level[g]),
      .overflow    (overflow[g]),
      .underflow   (underflow[g])
`ifdef SYNC_FIFO_PARITY_EN
      ,
      .parity_err  (parity_err[g])
`endif
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NumDut; i++) begin
      clr[i]     = 1'b0;
      wr_en[i]   = 1'b0;
      rd_en[i]   = 1'b0;
      wr_data[i] = 8'h00;
    end
  endtask

  task automatic check_reset(input int i);
    check_eq($sformatf("rst%0d_level", i), 32'(level[i]), 0);
    check_eq($sformatf("rst%0d_full", i), 32'(full[i]), 0);
    check_eq($sformatf("rst%0d_af", i), 32'(almost_full[i]), 0);
    check_eq($sformatf("rst%0d_empty", i), 32'(empty[i]), 1);
    check_eq($sformatf("rst%0d_has_data", i), 32'(has_data[i]), 0);
    check_eq($sformatf("rst%0d_ae", i), 32'(almost_empty[i]), 1);
    check_eq($sformatf("rst%0d_rd_data", i), 32'(rd_data[i]), 0);
    check_eq($sformatf("rst%0d_ovf", i), 32'(overflow[i]), 0);
    check_eq($sformatf("rst%0d_unf", i), 32'(underflow[i]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] q [$];
    logic [7:0] lfsr;
    logic [7:0] wv;
    logic [7:0] exp_v;
    int         n_wr;
    int         n_rd;
    logic       primed;

    rst_n = 1'b0;
    idle_all();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NumDut; i++) check_reset(i);

    // Standard mode: fill, overflow, drain in order.
    for (int k = 0; k < 16; k++) begin
      wr_en[IStd]   = 1'b1;
      wr_data[IStd] = 8'(k);
      tick();
      if (k == 14) begin
        check_eq("std_full_at15", 32'(full[IStd]), 0);
        check_eq("std_af_at15", 32'(almost_full[IStd]), 1);
      end
    end
    check_eq("std_full_at16", 32'(full[IStd]), 1);
    check_eq("std_level16", 32'(level[IStd]), 16);
    wr_data[IStd] = 8'hAA;
    tick();
    wr_en[IStd] = 1'b0;
    check_eq("std_overflow", 32'(overflow[IStd]), 1);
    check_eq("std_level_after_drop", 32'(level[IStd]), 16);
    rd_en[IStd] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      check_eq($sformatf("std_rd%0d", k), 32'(rd_data[IStd]), 32'(k));
    end
    rd_en[IStd] = 1'b0;
    check_eq("std_empty_after_drain", 32'(empty[IStd]), 1);
    check_eq("std_level_after_drain", 32'(level[IStd]), 0);
    check_eq("std_unf_clean", 32'(underflow[IStd]), 0);

    // RESERVE=2: full at 14, two more writes still stored.
    q.delete();
    for (int k = 0; k < 16; k++) begin
      wr_en[IRsv]   = 1'b1;
      wr_data[IRsv] = 8'h20 + 8'(k);
      q.push_back(8'h20 + 8'(k));
      tick();
      if (k == 12) check_eq("rsv_full_at13", 32'(full[IRsv]), 0);
      if (k == 13) begin
        check_eq("rsv_full_at14", 32'(full[IRsv]), 1);
        check_eq("rsv_level14", 32'(level[IRsv]), 14);
      end
    end
    wr_en[IRsv] = 1'b0;
    check_eq("rsv_level16", 32'(level[IRsv]), 16);
    check_eq("rsv_no_ovf", 32'(overflow[IRsv]), 0);

    // Simultaneous read+write at level 16.
    for (int k = 0; k < 8; k++) begin
      wv            = (k % 2 == 0) ? 8'h55 : 8'hAA;
      wr_en[IRsv]   = 1'b1;
      rd_en[IRsv]   = 1'b1;
      wr_data[IRsv] = wv;
      tick();
      exp_v = q.pop_front();
      q.push_back(wv);
      check_eq($sformatf("rw_rd%0d", k), 32'(rd_data[IRsv]), 32'(exp_v));
      check_eq($sformatf("rw_level%0d", k), 32'(level[IRsv]), 16);
      check_eq($sformatf("rw_ovf%0d", k), 32'(overflow[IRsv]), 0);
    end
    wr_en[IRsv] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_v = q.pop_front();
      check_eq($sformatf("rw_drain%0d", k), 32'(rd_data[IRsv]), 32'(exp_v));
    end
    rd_en[IRsv] = 1'b0;
    check_eq("rw_level_end", 32'(level[IRsv]), 0);
    check_eq("rw_empty_end", 32'(empty[IRsv]), 1);

    // FWFT latency: write at cycle N, data valid at N+2.
    wr_en[IFwft]   = 1'b1;
    wr_data[IFwft] = 8'hA5;
    tick();
    wr_en[IFwft] = 1'b0;
    check_eq("fwft_has_data_n1", 32'(has_data[IFwft]), 0);
    check_eq("fwft_level_n1", 32'(level[IFwft]), 1);
    tick();
    check_eq("fwft_has_data_n2", 32'(has_data[IFwft]), 1);
    check_eq("fwft_rd_data_n2", 32'(rd_data[IFwft]), 32'h A5);
    rd_en[IFwft] = 1'b1;
    tick();
    rd_en[IFwft] = 1'b0;
    check_eq("fwft_pop_empty", 32'(empty[IFwft]), 1);
    check_eq("fwft_pop_level", 32'(level[IFwft]), 0);

    // FWFT streaming of 100 LFSR words.
    q.delete();
    lfsr   = 8'hA5;
    n_wr   = 0;
    n_rd   = 0;
    primed = 1'b0;
    for (int cyc = 0; cyc < 400 && n_rd < 100; cyc++) begin
      if (has_data[IFwft]) primed = 1'b1;
      rd_en[IFwft] = 1'b0;
      if (primed && n_rd < 100) begin
        rd_en[IFwft] = 1'b1;
        check_eq($sformatf("fwft_no_bubble%0d", n_rd), 32'(has_data[IFwft]), 1);
        if (has_data[IFwft] && q.size() != 0) begin
          exp_v = q.pop_front();
          check_eq($sformatf("fwft_word%0d", n_rd), 32'(rd_data[IFwft]), 32'(exp_v));
          n_rd++;
        end
      end
      if (n_wr < 100) begin
        wr_en[IFwft]   = 1'b1;
        wr_data[IFwft] = lfsr;
        q.push_back(lfsr);
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        n_wr++;
      end else begin
        wr_en[IFwft] = 1'b0;
      end
      tick();
    end
    rd_en[IFwft] = 1'b0;
    wr_en[IFwft] = 1'b0;
    check_eq("fwft_stream_count", 32'(n_rd), 100);
    check_eq("fwft_stream_level", 32'(level[IFwft]), 0);
    check_eq("fwft_stream_has_data", 32'(has_data[IFwft]), 0);
    check_eq("fwft_stream_unf", 32'(underflow[IFwft]), 0);

    // Underflow, read/write at level 0, flush, reset.
    rd_en[IStd] = 1'b1;
    tick();
    rd_en[IStd] = 1'b0;
    check_eq("unf_set", 32'(underflow[IStd]), 1);
    check_eq("unf_rd_hold", 32'(rd_data[IStd]), 32'h0F);
    check_eq("unf_level", 32'(level[IStd]), 0);
    wr_en[IStd]   = 1'b1;
    rd_en[IStd]   = 1'b1;
    wr_data[IStd] = 8'h33;
    tick();
    rd_en[IStd] = 1'b0;
    check_eq("rw0_level", 32'(level[IStd]), 1);
    check_eq("rw0_empty", 32'(empty[IStd]), 0);
    check_eq("rw0_rd_hold", 32'(rd_data[IStd]), 32'h0F);
    for (int k = 0; k < 4; k++) begin
      wr_data[IStd] = 8'h34 + 8'(k);
      tick();
    end
    check_eq("pre_clr_level", 32'(level[IStd]), 5);
    clr[IStd]   = 1'b1;
    rd_en[IStd] = 1'b1;
    tick();
    idle_all();
    check_eq("clr_level", 32'(level[IStd]), 0);
    check_eq("clr_empty", 32'(empty[IStd]), 1);
    check_eq("clr_ae", 32'(almost_empty[IStd]), 1);
    check_eq("clr_rd_data", 32'(rd_data[IStd]), 0);
    check_eq("clr_unf_kept", 32'(underflow[IStd]), 1);
    check_eq("clr_ovf_kept", 32'(overflow[IStd]), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NumDut; i++) check_reset(i);

`ifdef SYNC_FIFO_PARITY_EN
    check_eq("par_clean", 32'(parity_err[IStd]), 0);
    wr_en[IStd]   = 1'b1;
    wr_data[IStd] = 8'hFF;
    tick();
    wr_en[IStd] = 1'b0;
    g_dut[0].u_dut.u_ram.mem_q[0] = g_dut[0].u_dut.u_ram.mem_q[0] ^ 9'h008;
    rd_en[IStd] = 1'b1;
    tick();
    rd_en[IStd] = 1'b0;
    check_eq("par_rd_data", 32'(rd_data[IStd]), 32'hF7);
    check_eq("par_err", 32'(parity_err[IStd]), 1);
    tick();
    check_eq("par_err_sticky", 32'(parity_err[IStd]), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_mode.md
Name: sync_fifo_mode

Overview:
Single-clock, parametrised successor to the dual-clock FIFO, for blocks that share one clock domain.
- Adds a selectable read mode: standard (registered read) or first-word-fall-through (FWFT).
- Adds occupancy count, almost-full/almost-empty watermarks, a synchronous flush, and sticky overflow/underflow flags.
- Sits between producer and consumer pipelines in the same clock domain.

Parameters:
DATA_WIDTH, 8, payload width in bits
ADDR_WIDTH, 4, log2 of storage depth; DEPTH = 2**ADDR_WIDTH
RESERVE, 0, slots held back: full asserts early; these slots still accept writes
FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through
AF_LEVEL, DEPTH-2, almost_full asserts when level >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  synchronous, active-low reset
clr  in  1  synchronous flush; empties the FIFO, sticky flags untouched
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write payload
full  out  1  level >= DEPTH-RESERVE
almost_full  out  1  level >= AF_LEVEL
rd_en  in  1  read request (standard) / pop (FWFT)
rd_data  out  DATA_WIDTH  read payload
empty  out  1  no readable word
has_data  out  1  equals !empty
almost_empty  out  1  level <= AE_LEVEL
level  out  ADDR_WIDTH+1  stored words (0..DEPTH), includes FWFT output register
overflow  out  1  sticky; a write was dropped
underflow  out  1  sticky; a read was issued while empty

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Pointers and level clear to 0.
  - full=0, almost_full=0, empty=1, has_data=0, almost_empty=1, rd_data=0, overflow=0, underflow=0.
  - Reset mid-operation discards contents.
- Write acceptance: a write is accepted if wr_en && (level<DEPTH || read accepted in the same cycle).
  - When level==DEPTH with no read: the write is dropped, memory is unchanged, and overflow is set.
- full honours RESERVE: with RESERVE=2 and DEPTH=16, full asserts at level 14, and writes at levels 14 and 15 are still stored.
- Standard mode (FWFT=0):
  - Read accepted if rd_en && !empty.
  - rd_data updates on the edge after acceptance and holds until the next accepted read.
  - A write into an empty FIFO deasserts empty the following cycle.
  - rd_en while empty: no pointer change, rd_data holds, underflow is set.
- FWFT mode (FWFT=1):
  - The head word is presented in an output register; has_data=1 means rd_data is valid now.
  - rd_en pops the head and is accepted if has_data.
  - A write into an empty FIFO sets has_data 2 cycles later (1 RAM read cycle + 1 register load).
  - Back-to-back pops at full rate sustain 1 word/cycle with no bubble: the prefetch refills on the pop edge.
  - rd_en with has_data=0 sets underflow.
- Simultaneous read and write:
  - Level is unchanged.
  - Legal at level==DEPTH in both modes.
  - At level 0 in standard mode the read is rejected (underflow) and the write is accepted.
- Level and flags:
  - level = accepted writes minus accepted reads, saturating within 0..DEPTH.
  - Flags are registered, derived combinationally from the next level, so they are consistent with level on every cycle.
- Pointers: ADDR_WIDTH+1 bits; wrap modulo 2*DEPTH; the MSB distinguishes full from empty.
- clr: on that edge, behaves like reset except overflow/underflow are retained; clr overrides same-cycle wr_en and rd_en.
- Sticky flags clear only on rst_n=0.

Optional Feature:
- Macro: SYNC_FIFO_PARITY_EN.
- When defined:
  - Storage is DATA_WIDTH+1 bits wide; even parity is generated on write and checked when a word leaves storage.
  - Extra output parity_err (1 bit, sticky, reset 0) sets when a popped/read word fails the check.
  - rd_data still returns the stored data bits unchanged.
- When undefined: no extra storage bit, no parity_err port, no checking logic.

Decomposition:
- Package sync_fifo_pkg holds:
  - typedef fifo_mode_e (MODE_STD, MODE_FWFT);
  - function clog2-safe level width;
  - constant PARITY_BITS (0 or 1 according to SYNC_FIFO_PARITY_EN).
- One sub-module, sync_fifo_ram:
  - simple dual-port, 1 write port and 1 registered read port, DEPTH x (DATA_WIDTH+PARITY_BITS);
  - no reset on the array.
- Top-level holds pointers, level, flags, and the FWFT prefetch.

Test Plan:
1. Standard, DEPTH=16, RESERVE=0: write 0x00..0x0F back-to-back → full=1 and level=16 after the last write; 17th write 0xAA → dropped, overflow=1; read 16 → 0x00..0x0F in order, then empty=1.
2. FWFT: write 0xA5 into empty at cycle N → has_data=1 and rd_data=0xA5 at N+2; stream 100 LFSR words (x^8+x^6+x^5+x^4+1, seed 0xA5) with rd_en held high → every word matches, no bubble once primed.
3. RESERVE=2: write 14 words → full=1 at level 14; 2 more writes → accepted, level=16, overflow=0.
4. At level 16, assert wr_en=rd_en=1 for 8 cycles with 0x55/0xAA → level stays 16, no overflow; data order is preserved on drain.
5. Read when empty (rd_en=1, level 0) → underflow=1, rd_data unchanged; then clr with level 5 → level=0, empty=1, underflow remains 1; rst_n=0 one cycle → all outputs at reset values.
6. SYNC_FIFO_PARITY_EN: force-flip bit 3 of a stored 0xFF via hierarchical deposit → parity_err=1 on that read, rd_data=0xF7.
